// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and width helpers for the synchronous FIFO
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

  // Pointer width: enough bits to index DEPTH entries, never less than one.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must hold the value DEPTH itself (0..DEPTH).
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - request/data/status bundle between FIFO and its user logic
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = count_width(DEPTH);

  logic             en;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             Empty;
  logic             Full;
  logic             AlmostEmpty;
  logic             AlmostFull;
  logic [CW-1:0]    Count;
  logic             Overflow;
  logic             Underflow;

  // User side: issues requests and write data, observes data and status.
  modport master (
    output en, we, re, data_in,
    input  data_out, Empty, Full, AlmostEmpty, AlmostFull, Count, Overflow, Underflow
  );

  // FIFO side.
  modport slave (
    input  en, we, re, data_in,
    output data_out, Empty, Full, AlmostEmpty, AlmostFull, Count, Overflow, Underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, synchronous write port, asynchronous read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: contents are never reset, only overwritten.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port reflects the pre-edge contents, so a same-edge write to the
  // read slot (full FIFO, read+write) still returns the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO; FIFO_FWFT_EN selects first-word fall-through output
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic               clk,
  input logic               rst,
  fifo_sync_param_if.slave  bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    count;
  logic             ovf_q;
  logic             udf_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] mem_rdata;
  logic             empty;
  logic             full;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A read frees a slot this very edge, so a full FIFO may accept a write
  // alongside it; an empty FIFO never pairs a read with the incoming write.
  assign rd_ok = bus.en & bus.re & ~empty;
  assign wr_ok = bus.en & bus.we & (~full | rd_ok);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wp),
    .wdata (bus.data_in),
    .raddr (rp),
    .rdata (mem_rdata)
  );

  // Pointers, occupancy, error pulses and the output word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        rp     <= rp + 1'b1;
        dout_q <= mem_rdata;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf_q <= bus.en & bus.we & ~wr_ok;
      udf_q <= bus.en & bus.re & ~rd_ok;
    end
  end

  assign bus.Count       = count;
  assign bus.Empty       = empty;
  assign bus.Full        = full;
  assign bus.AlmostEmpty = (int'(count) <= AE_LEVEL);
  assign bus.AlmostFull  = (int'(count) >= AF_LEVEL);
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = udf_q;

`ifdef FIFO_FWFT_EN
  // Head word shown directly; once drained, the last popped word is held.
  assign bus.data_out = empty ? dout_q : mem_rdata;
`else
  assign bus.data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed vector bench for fifo_sync_param (DEPTH=8, WIDTH=32)
module tb_fifo_sync_param;

  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic        re;
    logic [31:0] din;
    logic [31:0] dout;
    int          cnt;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [31:0] dout,
                             input logic ovf, input logic udf, input logic chk_dout);
    check({tag, " Count"}, 32'(bus.Count), 32'(cnt));
    check({tag, " Empty"}, 32'(bus.Empty), 32'(cnt == 0));
    check({tag, " Full"}, 32'(bus.Full), 32'(cnt == D));
    check({tag, " AlmostEmpty"}, 32'(bus.AlmostEmpty), 32'(cnt <= 2));
    check({tag, " AlmostFull"}, 32'(bus.AlmostFull), 32'(cnt >= 6));
    check({tag, " Overflow"}, 32'(bus.Overflow), 32'(ovf));
    check({tag, " Underflow"}, 32'(bus.Underflow), 32'(udf));
    if (chk_dout) check({tag, " data_out"}, bus.data_out, dout);
  endtask

  task automatic step(input logic en, input logic we, input logic re, input logic [31:0] din);
    @(negedge clk);
    bus.en = en; bus.we = we; bus.re = re; bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic en, input logic we, input logic re, input logic [31:0] din,
                              input logic [31:0] dout, input int cnt, input logic ovf, input logic udf);
    vec_t v;
    v.en = en; v.we = we; v.re = re; v.din = din;
    v.dout = dout; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.data_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] mdout;
    bit          rd_ok, wr_ok, we_i, re_i;

    bus.en = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.data_in = '0;
    rst = 1'b1;
    #100;
    check_state("reset", 0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

`ifdef FIFO_FWFT_EN
    step(1, 1, 0, 32'h11);
    check_state("fwft write", 1, 32'h11, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 32'h0);
    check_state("fwft hold", 1, 32'h11, 1'b0, 1'b0, 1'b1);
    step(1, 1, 0, 32'h22);
    check_state("fwft second", 2, 32'h11, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 32'h0);
    check_state("fwft pop1", 1, 32'h22, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 32'h0);
    check_state("fwft pop2", 0, 32'h22, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 32'h0);
    check_state("fwft underflow", 0, 32'h22, 1'b0, 1'b1, 1'b1);
`else
    // Basic 5-word write/readback, then one rejected read.
    for (int i = 0; i < 5; i++) add(1, 1, 0, 32'(i), 32'h0, i + 1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 32'h0, 32'(i), 4 - i, 0, 0);
    add(1, 0, 1, 32'h0, 32'h4, 0, 0, 1);
    add(1, 0, 0, 32'h0, 32'h4, 0, 0, 0);
    // Fill to DEPTH, overflow once.
    for (int i = 0; i < 8; i++) add(1, 1, 0, 32'h10 + 32'(i), 32'h4, i + 1, 0, 0);
    add(1, 1, 0, 32'hEE, 32'h4, 8, 1, 0);
    // Full: read+write A5 three times keeps occupancy at DEPTH.
    for (int i = 0; i < 3; i++) add(1, 1, 1, 32'hA5, 32'h10 + 32'(i), 8, 0, 0);
    // Drain: remaining originals then the three A5 words.
    for (int i = 0; i < 5; i++) add(1, 0, 1, 32'h0, 32'h13 + 32'(i), 7 - i, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 32'h0, 32'hA5, 2 - i, 0, 0);
    // Empty: read+write -> read rejected, write accepted.
    add(1, 1, 1, 32'h3C, 32'hA5, 1, 0, 1);
    add(1, 0, 1, 32'h0, 32'h3C, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].we, vecs[i].re, vecs[i].din);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].udf, 1'b1);
    end

    // Interleaved traffic with pointer wrap, checked against a queue model.
    mdout = 32'h3C;
    for (int i = 0; i < 20; i++) begin
      we_i  = (i % 3) != 2;
      re_i  = (i % 2) == 1;
      rd_ok = re_i && (q.size() > 0);
      wr_ok = we_i && ((q.size() < D) || rd_ok);
      step(1, we_i, re_i, 32'h100 + 32'(i));
      if (rd_ok) mdout = q.pop_front();
      if (wr_ok) q.push_back(32'h100 + 32'(i));
      check_state($sformatf("mix%0d", i), q.size(), mdout, we_i && !wr_ok, re_i && !rd_ok, 1'b1);
    end

    // Disabled requests change nothing and raise no pulses.
    step(0, 1, 1, 32'hDEAD);
    check_state("en0 a", q.size(), mdout, 1'b0, 1'b0, 1'b1);
    step(0, 1, 1, 32'hBEEF);
    check_state("en0 b", q.size(), mdout, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 32'h0);
    mdout = q.pop_front();
    check_state("en0 after", q.size(), mdout, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-burst with Count=5.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h200 + 32'(i));
    step(1, 1, 1, 32'h206);
    step(1, 0, 1, 32'h0);
    check_state("pre-rst", 5, 32'h201, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.re = 1'b1; bus.we = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_state("async rst", 0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.en = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
    rst = 1'b0;
    step(1, 0, 1, 32'h0);
    check_state("post-rst read", 0, 32'h0, 1'b0, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
